q_window_accumulator: RTL and testbench

// Sequencer and accumulator directly downstream of q_measurement. Drives q_measurement's start,

---
 rtl/q_meas_pkg.sv | 12 +
 rtl/q_sat_accumulator.sv | 25 ++
 rtl/q_window_accumulator.sv | 100 ++++++++++
 tb/tb_q_window_accumulator.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/q_meas_pkg.sv
// q_meas_pkg: shared states, bus width default and saturating add for the q_measurement chain
package q_meas_pkg;
  localparam int Q_BUS_WIDTH = 10;
  typedef enum logic [2:0] {S_IDLE, S_ARM, S_CAPTURE, S_GAP, S_DONE} state_t;
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int width);
    logic [32:0] s;
    logic [32:0] lim;
    s = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << width) - 33'd1;
    return (s > lim) ? lim[31:0] : s[31:0];
  endfunction
endpackage

// File: rtl/q_sat_accumulator.sv
// q_sat_accumulator: saturating window sum and unsigned running peak of accepted samples
module q_sat_accumulator
  import q_meas_pkg::*;
#(
  parameter int BUS_WIDTH = Q_BUS_WIDTH,
  parameter int SUM_WIDTH = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 add_en,
  input  logic [BUS_WIDTH-1:0] sample,
  output logic [SUM_WIDTH-1:0] sum,
  output logic [BUS_WIDTH-1:0] peak
);
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      sum <= '0;
      peak <= '0;
    end else if (add_en) begin
      sum <= SUM_WIDTH'(sat_add(32'(sum), 32'(sample), SUM_WIDTH));
      peak <= (sample > peak) ? sample : peak;
    end
  end
endmodule

// File: rtl/q_window_accumulator.sv
// q_window_accumulator: sequences q_measurement, sums N_SAMPLES results per window with
// peak and timeout count, and publishes each window on a valid/ack handshake
module q_window_accumulator
  import q_meas_pkg::*;
#(
  parameter int BUS_WIDTH  = Q_BUS_WIDTH,
  parameter int N_SAMPLES  = 8,
  parameter int SUM_WIDTH  = 13,
  parameter int GAP_CYCLES = 2,
  parameter int TMO_WIDTH  = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           ready,
  input  logic [BUS_WIDTH-1:0]           q_measured,
  output logic                           start,
  output logic [SUM_WIDTH-1:0]           q_sum,
  output logic [BUS_WIDTH-1:0]           q_peak,
  output logic [$clog2(N_SAMPLES+1)-1:0] n_timeouts,
  output logic                           sum_valid,
  input  logic                           sum_ack,
  output logic                           busy
);
  localparam int NW = $clog2(N_SAMPLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'((2 ** TMO_WIDTH) - 2);
  state_t state, state_nxt;
  logic [NW-1:0] sample_cnt, tmo_acc;
  logic [GW-1:0] gap_cnt;
  logic [TMO_WIDTH-1:0] tmo_cnt;
  logic [BUS_WIDTH-1:0] sample_q, acc_peak;
  logic [SUM_WIDTH-1:0] acc;
  logic tmo_hit, arm_exit, ack_take, last_sample, gap_end, acc_clear, add_en;
  // the timeout fires on the limit-th ARM cycle; a simultaneous ready takes priority
  assign tmo_hit = state == S_ARM && !ready && tmo_cnt == TMO_LAST;
  assign arm_exit = state == S_ARM && (ready || tmo_hit);
  assign ack_take = state == S_DONE && sum_valid && sum_ack;
  assign last_sample = sample_cnt == NW'(N_SAMPLES - 1);
  assign gap_end = gap_cnt == GW'(GAP_CYCLES - 1);
  assign acc_clear = state == S_IDLE || ack_take;
  assign add_en = state == S_CAPTURE;
  assign start = state == S_ARM;
  assign busy = state != S_IDLE;
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    state_nxt = enable ? S_ARM : S_IDLE;
      S_ARM:     state_nxt = arm_exit ? S_CAPTURE : S_ARM;
      S_CAPTURE: state_nxt = last_sample ? S_DONE : S_GAP;
      S_GAP:     state_nxt = gap_end ? S_ARM : S_GAP;
      S_DONE:    state_nxt = ack_take ? (enable ? S_GAP : S_IDLE) : S_DONE;
      default:   state_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      tmo_cnt <= '0;
      gap_cnt <= '0;
      sample_cnt <= '0;
      tmo_acc <= '0;
      sample_q <= '0;
      sum_valid <= 1'b0;
      q_sum <= '0;
      q_peak <= '0;
      n_timeouts <= '0;
    end else begin
      state <= state_nxt;
      tmo_cnt <= (state == S_ARM) ? tmo_cnt + 1'b1 : '0;
      gap_cnt <= (state == S_GAP) ? gap_cnt + 1'b1 : '0;
      if (arm_exit) sample_q <= ready ? q_measured : '0;
      if (acc_clear) begin
        sample_cnt <= '0;
        tmo_acc <= '0;
      end else begin
        if (add_en) sample_cnt <= sample_cnt + 1'b1;
        if (tmo_hit) tmo_acc <= tmo_acc + 1'b1;
      end
      // first DONE cycle publishes the finished accumulator; it then holds until acked
      if (state == S_DONE && !sum_valid) begin
        sum_valid <= 1'b1;
        q_sum <= acc;
        q_peak <= acc_peak;
        n_timeouts <= tmo_acc;
      end else if (ack_take) begin
        sum_valid <= 1'b0;
      end
    end
  end
  q_sat_accumulator #(.BUS_WIDTH(BUS_WIDTH), .SUM_WIDTH(SUM_WIDTH)) u_acc (
    .clk(clk),
    .rst(rst),
    .clear(acc_clear),
    .add_en(add_en),
    .sample(sample_q),
    .sum(acc),
    .peak(acc_peak)
  );
endmodule

// File: tb/tb_q_window_accumulator.sv
// tb_q_window_accumulator: emulates the upstream measurement and checks each window against
// a sample-level model (saturating sum, peak, timeout count, handshake and timing)
module tb_q_window_accumulator;
  localparam int BW = 10, NS = 4, SW = 10, GC = 2, TW = 4;
  localparam int NTW = $clog2(NS + 1);
  localparam int TMO_LIMIT = 2 ** TW - 1;
  localparam int RESP_DLY = 3;
  localparam int SAT = 2 ** SW - 1;
  typedef struct {int sum; int peak; int nt; int done_cyc;} win_t;
  logic clk = 0, rst = 0, enable = 0, ready = 0, sum_ack = 0;
  logic [BW-1:0] q_measured = '0;
  logic start, sum_valid, busy;
  logic [SW-1:0] q_sum;
  logic [BW-1:0] q_peak;
  logic [NTW-1:0] n_timeouts;
  win_t exp_q[$];
  win_t e;
  int vals[$];
  int n_chk = 0, n_bad = 0, cyc = 0;
  int meas_in_win = 0, win_sum = 0, win_peak = 0, win_nt = 0, smp = 0;
  int arm_cyc = 0, cur = -1, low_run = 0;
  logic in_arm = 0, responded = 0, prev_valid = 0, ack_taken = 0, rst_at_edge = 0;
  logic [SW+BW+NTW-1:0] held = '0;

  q_window_accumulator #(.BUS_WIDTH(BW), .N_SAMPLES(NS), .SUM_WIDTH(SW), .GAP_CYCLES(GC), .TMO_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .ready(ready), .q_measured(q_measured),
    .start(start), .q_sum(q_sum), .q_peak(q_peak), .n_timeouts(n_timeouts),
    .sum_valid(sum_valid), .sum_ack(sum_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ack_taken <= sum_ack && sum_valid;
    rst_at_edge <= rst;
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endfunction

  // upstream emulation plus model and compare, evaluated once per cycle on the falling edge
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst_at_edge) begin
      check("reset_outs", 32'({start, busy, sum_valid, q_sum, q_peak, n_timeouts}), 0);
      exp_q.delete();
      in_arm = 0; meas_in_win = 0; win_sum = 0; win_peak = 0; win_nt = 0;
      low_run = 0; prev_valid = 0; ready = 0;
    end else begin
      if (sum_valid && !prev_valid) begin
        if (exp_q.size() == 0) check("spurious_valid", 32'(sum_valid), 0);
        else begin
          e = exp_q.pop_front();
          check("latency", cyc, e.done_cyc + 2);
          check("sum", 32'(q_sum), e.sum);
          check("peak", 32'(q_peak), e.peak);
          check("n_timeouts", 32'(n_timeouts), e.nt);
        end
        held = {q_sum, q_peak, n_timeouts};
      end else if (sum_valid) check("hold", 32'({q_sum, q_peak, n_timeouts}), 32'(held));
      if (sum_valid) check("start_in_done", 32'(start), 0);
      if (ack_taken) check("ack_drop", 32'(sum_valid), 0);
      if (start || sum_valid) check("busy", 32'(busy), 1);
      prev_valid = sum_valid;
      if (start) begin
        if (!in_arm) begin
          if (meas_in_win != 0) check("gap_len", low_run, GC + 1);
          in_arm = 1; arm_cyc = 0; responded = 0;
          cur = (vals.size() != 0) ? vals.pop_front() : -1;
        end
        arm_cyc++;
        if (!responded && cur >= 0 && arm_cyc == RESP_DLY) begin
          ready = 1; q_measured = BW'(cur); responded = 1;
        end
      end else begin
        if (in_arm) begin
          check("arm_len", arm_cyc, responded ? RESP_DLY : TMO_LIMIT);
          smp = responded ? cur : 0;
          win_sum = (win_sum + smp > SAT) ? SAT : win_sum + smp;
          win_peak = (smp > win_peak) ? smp : win_peak;
          win_nt += responded ? 0 : 1;
          meas_in_win++;
          if (meas_in_win == NS) begin
            exp_q.push_back('{win_sum, win_peak, win_nt, cyc});
            meas_in_win = 0; win_sum = 0; win_peak = 0; win_nt = 0;
          end
          in_arm = 0; low_run = 0;
        end
        ready = 0;
        low_run++;
      end
    end
  end

  task automatic wait_valid(input int lim);
    for (int i = 0; i < lim && sum_valid !== 1'b1; i++) @(negedge clk);
    check("wait_valid", 32'(sum_valid), 1);
  endtask

  task automatic do_ack();
    sum_ack = 1;
    @(negedge clk);
    sum_ack = 0;
  endtask

  task automatic expect_win(input int s, input int p, input int t);
    check("lit_sum", 32'(q_sum), s);
    check("lit_peak", 32'(q_peak), p);
    check("lit_nt", 32'(n_timeouts), t);
  endtask

  initial begin
    vals = '{30, 60, 90, 30, 1023, 1023, 5, 0, -1, -1, -1, -1, 100, -1, 7, 200};
    repeat (3) @(negedge clk);
    check("lit_reset", 32'({start, busy, sum_valid, q_sum}), 0);
    rst = 1;
    repeat (3) @(negedge clk);
    check("idle_start", 32'(start), 0);
    check("idle_busy", 32'(busy), 0);
    enable = 1;
    repeat (10) @(negedge clk);
    do_ack();
    wait_valid(300);
    expect_win(210, 90, 0);
    repeat (20) @(negedge clk);
    check("stall_sum", 32'(q_sum), 210);
    check("stall_start", 32'(start), 0);
    check("stall_valid", 32'(sum_valid), 1);
    do_ack();
    check("lit_ack_drop", 32'(sum_valid), 0);
    check("lit_new_window", 32'(busy), 1);
    wait_valid(300);
    expect_win(1023, 1023, 0);
    do_ack();
    wait_valid(400);
    expect_win(0, 0, 4);
    do_ack();
    wait_valid(300);
    expect_win(307, 200, 1);
    vals = '{10, 20, 30, 40};
    do_ack();
    for (int i = 0; i < 100 && !(meas_in_win == 1 && start === 1'b1); i++) @(negedge clk);
    check("reach_sample2", 32'(start), 1);
    enable = 0;
    wait_valid(300);
    expect_win(100, 40, 0);
    do_ack();
    repeat (3) @(negedge clk);
    check("drop_busy", 32'(busy), 0);
    repeat (10) @(negedge clk);
    check("drop_start", 32'(start), 0);
    vals = '{-1, 5, 6, 7, 8};
    enable = 1;
    for (int i = 0; i < 50 && start !== 1'b1; i++) @(negedge clk);
    check("arm_reached", 32'(start), 1);
    repeat (4) @(negedge clk);
    rst = 0;
    @(negedge clk);
    rst = 1;
    check("mid_rst_start", 32'(start), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_sum", 32'(q_sum), 0);
    wait_valid(300);
    expect_win(26, 8, 0);
    enable = 0;
    do_ack();
    repeat (3) @(negedge clk);
    check("end_busy", 32'(busy), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
